// File: rtl/cosim_commit_packer.sv
// Compacts a sparse per-cycle commit trace into an in-order record FIFO and drains it
// as contiguous lowest-lane-first bundles, emitting traps with the last preceding record.
module cosim_commit_packer #(
    parameter int COMMIT_WIDTH = 2,
    parameter int XLEN         = 64,
    parameter int INST_BITS    = 32,
    parameter int RD           = 5,
    parameter int HARTID_LEN   = 1,
    parameter int DEPTH        = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [COMMIT_WIDTH-1:0]      in_valid,
    input  logic [XLEN*COMMIT_WIDTH-1:0] in_pc,
    input  logic [XLEN*COMMIT_WIDTH-1:0] in_wdata,
    input  logic [XLEN*COMMIT_WIDTH-1:0] in_mstatus,
    input  logic [INST_BITS*COMMIT_WIDTH-1:0] in_inst,
    input  logic [COMMIT_WIDTH-1:0]      in_check,
    input  logic [COMMIT_WIDTH-1:0]      in_wdata_valid,
    input  logic [COMMIT_WIDTH-1:0]      in_insn_writes_back,
    input  logic [RD*COMMIT_WIDTH-1:0]   in_wdata_dest,
    input  logic [RD*COMMIT_WIDTH-1:0]   in_insn_wdata_dest,
    input  logic                         in_int_xcpt,
    input  logic [XLEN-1:0]              in_cause,
    input  logic [HARTID_LEN-1:0]        in_hartid,
    input  logic                         out_ready,
    output logic [COMMIT_WIDTH-1:0]      out_valid,
    output logic [XLEN*COMMIT_WIDTH-1:0] out_pc,
    output logic [XLEN*COMMIT_WIDTH-1:0] out_wdata,
    output logic [XLEN*COMMIT_WIDTH-1:0] out_mstatus,
    output logic [INST_BITS*COMMIT_WIDTH-1:0] out_inst,
    output logic [COMMIT_WIDTH-1:0]      out_check,
    output logic [COMMIT_WIDTH-1:0]      out_wdata_valid,
    output logic [COMMIT_WIDTH-1:0]      out_insn_writes_back,
    output logic [RD*COMMIT_WIDTH-1:0]   out_wdata_dest,
    output logic [RD*COMMIT_WIDTH-1:0]   out_insn_wdata_dest,
    output logic                         out_int_xcpt,
    output logic [XLEN-1:0]              out_cause,
    output logic [HARTID_LEN-1:0]        out_hartid,
    output logic                         overflow,
    output logic                         trap_overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0]      pc;
        logic [INST_BITS-1:0] inst;
        logic [XLEN-1:0]      wdata;
        logic [XLEN-1:0]      mstatus;
        logic                 check;
        logic                 wdata_valid;
        logic [RD-1:0]        wdata_dest;
        logic                 insn_writes_back;
        logic [RD-1:0]        insn_wdata_dest;
    } rec_t;

    rec_t                    fifo_q    [DEPTH];
    rec_t                    in_rec    [COMMIT_WIDTH];
    rec_t                    out_rec_q [COMMIT_WIDTH];
    logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]           occ_q, trap_cnt_q;
    logic                    trap_pend_q;
    logic [XLEN-1:0]         trap_cause_q;
    logic [COMMIT_WIDTH-1:0] out_valid_q;
    logic                    out_int_xcpt_q, overflow_q, trap_overflow_q;
    logic [XLEN-1:0]         out_cause_q;
    logic [HARTID_LEN-1:0]   out_hartid_q;

    logic [CW-1:0] pop, n, post_pop, enq_n;
    logic [PW-1:0] wr_off [COMMIT_WIDTH];
    logic          accept, emit, take_trap;

    for (genvar g = 0; g < COMMIT_WIDTH; g++) begin : g_lane
        assign in_rec[g] = '{
            pc:               in_pc[(g+1)*XLEN-1 -: XLEN],
            inst:             in_inst[(g+1)*INST_BITS-1 -: INST_BITS],
            wdata:            in_wdata[(g+1)*XLEN-1 -: XLEN],
            mstatus:          in_mstatus[(g+1)*XLEN-1 -: XLEN],
            check:            in_check[g],
            wdata_valid:      in_wdata_valid[g],
            wdata_dest:       in_wdata_dest[(g+1)*RD-1 -: RD],
            insn_writes_back: in_insn_writes_back[g],
            insn_wdata_dest:  in_insn_wdata_dest[(g+1)*RD-1 -: RD]
        };
        assign out_pc[(g+1)*XLEN-1 -: XLEN]               = out_rec_q[g].pc;
        assign out_inst[(g+1)*INST_BITS-1 -: INST_BITS]   = out_rec_q[g].inst;
        assign out_wdata[(g+1)*XLEN-1 -: XLEN]            = out_rec_q[g].wdata;
        assign out_mstatus[(g+1)*XLEN-1 -: XLEN]          = out_rec_q[g].mstatus;
        assign out_check[g]                               = out_rec_q[g].check;
        assign out_wdata_valid[g]                         = out_rec_q[g].wdata_valid;
        assign out_wdata_dest[(g+1)*RD-1 -: RD]           = out_rec_q[g].wdata_dest;
        assign out_insn_writes_back[g]                    = out_rec_q[g].insn_writes_back;
        assign out_insn_wdata_dest[(g+1)*RD-1 -: RD]      = out_rec_q[g].insn_wdata_dest;
    end

    always_comb begin
        pop = '0;
        if (out_ready) begin
            pop = (occ_q < CW'(COMMIT_WIDTH)) ? occ_q : CW'(COMMIT_WIDTH);
            // A pending trap caps the pop so the trap lands with its last preceding record.
            if (trap_pend_q && (trap_cnt_q < pop)) pop = trap_cnt_q;
        end
        n = '0;
        for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
            wr_off[i] = PW'(n);
            if (in_valid[i]) n = n + CW'(1);
        end
        post_pop  = occ_q - pop;
        accept    = ({1'b0, post_pop} + {1'b0, n}) <= (CW+1)'(DEPTH);
        enq_n     = accept ? n : '0;
        emit      = trap_pend_q && out_ready && (pop == trap_cnt_q);
        take_trap = in_int_xcpt && (!trap_pend_q || emit);
    end

    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
            if (reset && accept && in_valid[i]) fifo_q[wr_ptr_q + wr_off[i]] <= in_rec[i];
            out_rec_q[i] <= fifo_q[rd_ptr_q + PW'(i)];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            occ_q           <= '0;
            trap_pend_q     <= 1'b0;
            trap_cnt_q      <= '0;
            trap_cause_q    <= '0;
            out_valid_q     <= '0;
            out_int_xcpt_q  <= 1'b0;
            out_cause_q     <= '0;
            out_hartid_q    <= '0;
            overflow_q      <= 1'b0;
            trap_overflow_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PW'(enq_n);
            rd_ptr_q <= rd_ptr_q + PW'(pop);
            occ_q    <= post_pop + enq_n;
            for (int unsigned i = 0; i < COMMIT_WIDTH; i++) out_valid_q[i] <= CW'(i) < pop;
            out_int_xcpt_q <= emit;
            if (emit) out_cause_q <= trap_cause_q;
            out_hartid_q    <= in_hartid;
            overflow_q      <= overflow_q | !accept;
            trap_overflow_q <= trap_overflow_q | (in_int_xcpt && !take_trap);
            if (take_trap) begin
                trap_pend_q  <= 1'b1;
                trap_cause_q <= in_cause;
                trap_cnt_q   <= post_pop + enq_n;
            end else if (emit) begin
                trap_pend_q <= 1'b0;
            end else if (trap_pend_q) begin
                trap_cnt_q <= trap_cnt_q - pop;
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign out_int_xcpt  = out_int_xcpt_q;
    assign out_cause     = out_cause_q;
    assign out_hartid    = out_hartid_q;
    assign overflow      = overflow_q;
    assign trap_overflow = trap_overflow_q;
endmodule

// File: tb/tb_cosim_commit_packer.sv
// Directed bench for cosim_commit_packer: sparse compaction, trap ordering/splitting,
// overflow, trap overflow and reset behaviour with hand-computed expectations.
module tb_cosim_commit_packer;
    localparam int W = 2;
    localparam int XL = 64;
    localparam int IB = 32;
    localparam int RDW = 5;

    logic             clock = 1'b0;
    logic             reset;
    logic [W-1:0]     in_valid;
    logic [XL*W-1:0]  in_pc, in_wdata, in_mstatus;
    logic [IB*W-1:0]  in_inst;
    logic [W-1:0]     in_check, in_wdata_valid, in_insn_writes_back;
    logic [RDW*W-1:0] in_wdata_dest, in_insn_wdata_dest;
    logic             in_int_xcpt;
    logic [XL-1:0]    in_cause;
    logic [0:0]       in_hartid;
    logic             out_ready;
    logic [W-1:0]     out_valid;
    logic [XL*W-1:0]  out_pc, out_wdata, out_mstatus;
    logic [IB*W-1:0]  out_inst;
    logic [W-1:0]     out_check, out_wdata_valid, out_insn_writes_back;
    logic [RDW*W-1:0] out_wdata_dest, out_insn_wdata_dest;
    logic             out_int_xcpt;
    logic [XL-1:0]    out_cause;
    logic [0:0]       out_hartid;
    logic             overflow, trap_overflow;

    int passed = 0;
    int total  = 0;

    cosim_commit_packer #(.COMMIT_WIDTH(W), .XLEN(XL), .INST_BITS(IB), .RD(RDW),
                          .HARTID_LEN(1), .DEPTH(16)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_pc(in_pc),
        .in_wdata(in_wdata), .in_mstatus(in_mstatus), .in_inst(in_inst),
        .in_check(in_check), .in_wdata_valid(in_wdata_valid),
        .in_insn_writes_back(in_insn_writes_back), .in_wdata_dest(in_wdata_dest),
        .in_insn_wdata_dest(in_insn_wdata_dest), .in_int_xcpt(in_int_xcpt),
        .in_cause(in_cause), .in_hartid(in_hartid), .out_ready(out_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_wdata(out_wdata),
        .out_mstatus(out_mstatus), .out_inst(out_inst), .out_check(out_check),
        .out_wdata_valid(out_wdata_valid), .out_insn_writes_back(out_insn_writes_back),
        .out_wdata_dest(out_wdata_dest), .out_insn_wdata_dest(out_insn_wdata_dest),
        .out_int_xcpt(out_int_xcpt), .out_cause(out_cause), .out_hartid(out_hartid),
        .overflow(overflow), .trap_overflow(trap_overflow)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        in_valid = '0; in_pc = '0; in_wdata = '0; in_mstatus = '0; in_inst = '0;
        in_check = '0; in_wdata_valid = '0; in_insn_writes_back = '0;
        in_wdata_dest = '0; in_insn_wdata_dest = '0; in_int_xcpt = 1'b0; in_cause = '0;
    endtask

    task automatic set_lane(input int i, input logic [63:0] pc);
        in_valid[i]                 = 1'b1;
        in_pc[i*XL +: XL]           = pc;
        in_inst[i*IB +: IB]         = pc[31:0] ^ 32'h0000_0013;
        in_wdata[i*XL +: XL]        = ~pc;
        in_mstatus[i*XL +: XL]      = pc;
        in_check[i]                 = 1'b1;
        in_wdata_valid[i]           = 1'b1;
        in_wdata_dest[i*RDW +: RDW] = pc[6:2];
    endtask

    function automatic logic [63:0] opc(input int i);
        return out_pc[i*XL +: XL];
    endfunction

    function automatic logic [31:0] oinst(input int i);
        return out_inst[i*IB +: IB];
    endfunction

    task automatic test_reset();
        idle();
        in_valid = 2'b11; in_int_xcpt = 1'b1; in_cause = 64'h5; in_hartid = 1'b1;
        out_ready = 1'b1; reset = 1'b0;
        tick(); tick();
        total++; if (out_valid !== 2'b00) $display("FAIL reset_valid got %b exp 00", out_valid); else passed++;
        total++; if (out_int_xcpt !== 1'b0) $display("FAIL reset_xcpt got %b exp 0", out_int_xcpt); else passed++;
        total++; if (out_cause !== 64'h0) $display("FAIL reset_cause got %h exp 0", out_cause); else passed++;
        total++; if (out_hartid !== 1'b0) $display("FAIL reset_hartid got %b exp 0", out_hartid); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b exp 0", overflow); else passed++;
        total++; if (trap_overflow !== 1'b0) $display("FAIL reset_trap_overflow got %b exp 0", trap_overflow); else passed++;
        idle(); reset = 1'b1;
        tick();
        total++; if (out_hartid !== 1'b1) $display("FAIL hartid_pass got %b exp 1", out_hartid); else passed++;
        tick();
        total++; if (out_valid !== 2'b00) $display("FAIL post_reset_valid got %b exp 00", out_valid); else passed++;
    endtask

    task automatic test_sparse();
        out_ready = 1'b1;
        idle(); set_lane(1, 64'h8000_0004);
        tick(); idle();
        total++; if (out_valid !== 2'b00) $display("FAIL sparse_early got %b exp 00", out_valid); else passed++;
        tick();
        total++; if (out_valid !== 2'b01) $display("FAIL sparse_valid got %b exp 01", out_valid); else passed++;
        total++; if (opc(0) !== 64'h8000_0004) $display("FAIL sparse_pc got %h exp 80000004", opc(0)); else passed++;
        total++; if (oinst(0) !== 32'h8000_0017) $display("FAIL sparse_inst got %h exp 80000017", oinst(0)); else passed++;
        tick();
        total++; if (out_valid !== 2'b00) $display("FAIL sparse_drained got %b exp 00", out_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            idle(); set_lane(0, 64'h3000 + 64'(8*k)); set_lane(1, 64'h3004 + 64'(8*k));
            tick();
            if (k >= 1) begin
                total++; if (out_valid !== 2'b11) $display("FAIL b2b_valid[%0d] got %b exp 11", k-1, out_valid); else passed++;
                total++; if (opc(0) !== 64'h3000 + 64'(8*(k-1))) $display("FAIL b2b_pc0[%0d] got %h exp %h", k-1, opc(0), 64'h3000 + 64'(8*(k-1))); else passed++;
                total++; if (opc(1) !== 64'h3004 + 64'(8*(k-1))) $display("FAIL b2b_pc1[%0d] got %h exp %h", k-1, opc(1), 64'h3004 + 64'(8*(k-1))); else passed++;
            end
        end
        idle(); tick();
        total++; if (out_valid !== 2'b11 || opc(0) !== 64'h3018) $display("FAIL b2b_last got %b/%h exp 11/3018", out_valid, opc(0)); else passed++;
        tick();
        total++; if (out_valid !== 2'b00) $display("FAIL b2b_drained got %b exp 00", out_valid); else passed++;
    endtask

    task automatic test_trap_order();
        out_ready = 1'b1;
        idle(); set_lane(0, 64'h100); set_lane(1, 64'h104);
        in_int_xcpt = 1'b1; in_cause = 64'h8000_0000_0000_0007;
        tick(); idle();
        total++; if (out_int_xcpt !== 1'b0) $display("FAIL order_early_xcpt got %b exp 0", out_int_xcpt); else passed++;
        tick();
        total++; if (out_valid !== 2'b11) $display("FAIL order_valid got %b exp 11", out_valid); else passed++;
        total++; if (opc(0) !== 64'h100 || opc(1) !== 64'h104) $display("FAIL order_pcs got %h,%h exp 100,104", opc(0), opc(1)); else passed++;
        total++; if (out_int_xcpt !== 1'b1) $display("FAIL order_xcpt got %b exp 1", out_int_xcpt); else passed++;
        total++; if (out_cause !== 64'h8000_0000_0000_0007) $display("FAIL order_cause got %h exp 8000000000000007", out_cause); else passed++;
        tick();
        total++; if (out_int_xcpt !== 1'b0) $display("FAIL order_pulse got %b exp 0", out_int_xcpt); else passed++;
    endtask

    task automatic test_trap_split();
        out_ready = 1'b0;
        idle(); set_lane(0, 64'h200); set_lane(1, 64'h204); tick();
        idle(); set_lane(0, 64'h208); tick();
        idle(); in_int_xcpt = 1'b1; in_cause = 64'h5; tick();
        idle(); tick();
        total++; if (out_valid !== 2'b00) $display("FAIL split_hold got %b exp 00", out_valid); else passed++;
        out_ready = 1'b1; tick();
        total++; if (out_valid !== 2'b11) $display("FAIL split_b1_valid got %b exp 11", out_valid); else passed++;
        total++; if (opc(0) !== 64'h200 || opc(1) !== 64'h204) $display("FAIL split_b1_pcs got %h,%h exp 200,204", opc(0), opc(1)); else passed++;
        total++; if (out_int_xcpt !== 1'b0) $display("FAIL split_b1_xcpt got %b exp 0", out_int_xcpt); else passed++;
        tick();
        total++; if (out_valid !== 2'b01) $display("FAIL split_b2_valid got %b exp 01", out_valid); else passed++;
        total++; if (opc(0) !== 64'h208) $display("FAIL split_b2_pc got %h exp 208", opc(0)); else passed++;
        total++; if (out_int_xcpt !== 1'b1 || out_cause !== 64'h5) $display("FAIL split_b2_xcpt got %b/%h exp 1/5", out_int_xcpt, out_cause); else passed++;
        tick();
        total++; if (out_valid !== 2'b00 || out_int_xcpt !== 1'b0) $display("FAIL split_end got %b/%b exp 00/0", out_valid, out_int_xcpt); else passed++;
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int g = 0; g < 9; g++) begin
            idle(); set_lane(0, 64'h1000 + 64'(8*g)); set_lane(1, 64'h1004 + 64'(8*g));
            tick();
            if (g == 7) begin
                total++; if (overflow !== 1'b0) $display("FAIL ovf_early got %b exp 0", overflow); else passed++;
            end
        end
        idle();
        total++; if (overflow !== 1'b1) $display("FAIL ovf_set got %b exp 1", overflow); else passed++;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            total++; if (out_valid !== 2'b11 || opc(0) !== 64'h1000 + 64'(8*k) || opc(1) !== 64'h1004 + 64'(8*k))
                $display("FAIL ovf_drain[%0d] got %b %h,%h exp 11 %h,%h", k, out_valid, opc(0), opc(1),
                         64'h1000 + 64'(8*k), 64'h1004 + 64'(8*k));
            else passed++;
        end
        tick();
        total++; if (out_valid !== 2'b00) $display("FAIL ovf_dropped got %b exp 00", out_valid); else passed++;
    endtask

    task automatic test_trap_overflow();
        out_ready = 1'b0;
        idle(); in_int_xcpt = 1'b1; in_cause = 64'h11; tick();
        idle(); in_int_xcpt = 1'b1; in_cause = 64'h22; tick();
        idle();
        total++; if (trap_overflow !== 1'b1) $display("FAIL trapovf_set got %b exp 1", trap_overflow); else passed++;
        out_ready = 1'b1; tick();
        total++; if (out_int_xcpt !== 1'b1 || out_cause !== 64'h11) $display("FAIL trapovf_first got %b/%h exp 1/11", out_int_xcpt, out_cause); else passed++;
        total++; if (out_valid !== 2'b00) $display("FAIL trapovf_lanes got %b exp 00", out_valid); else passed++;
        tick();
        total++; if (out_int_xcpt !== 1'b0) $display("FAIL trapovf_second got %b exp 0", out_int_xcpt); else passed++;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        idle(); set_lane(0, 64'h400); set_lane(1, 64'h404); tick();
        idle(); set_lane(0, 64'h408); set_lane(1, 64'h40c); tick();
        idle(); set_lane(0, 64'h410); tick();
        idle(); in_int_xcpt = 1'b1; in_cause = 64'h9; tick();
        idle(); reset = 1'b0; tick();
        total++; if (out_valid !== 2'b00 || out_int_xcpt !== 1'b0) $display("FAIL rmid_out got %b/%b exp 00/0", out_valid, out_int_xcpt); else passed++;
        total++; if (out_cause !== 64'h0 || out_hartid !== 1'b0) $display("FAIL rmid_cause got %h/%b exp 0/0", out_cause, out_hartid); else passed++;
        total++; if (overflow !== 1'b0 || trap_overflow !== 1'b0) $display("FAIL rmid_sticky got %b/%b exp 0/0", overflow, trap_overflow); else passed++;
        reset = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (out_valid !== 2'b00 || out_int_xcpt !== 1'b0) $display("FAIL rmid_stale[%0d] got %b/%b exp 00/0", k, out_valid, out_int_xcpt); else passed++;
        end
        set_lane(0, 64'h5000); set_lane(1, 64'h5004); tick();
        idle(); tick();
        total++; if (out_valid !== 2'b11 || opc(0) !== 64'h5000 || opc(1) !== 64'h5004) $display("FAIL rmid_fresh got %b %h,%h exp 11 5000,5004", out_valid, opc(0), opc(1)); else passed++;
        tick();
        total++; if (out_valid !== 2'b00 || out_int_xcpt !== 1'b0) $display("FAIL rmid_end got %b/%b exp 00/0", out_valid, out_int_xcpt); else passed++;
    endtask

    initial begin
        idle(); reset = 1'b0; out_ready = 1'b0; in_hartid = 1'b0;
        test_reset();
        test_sparse();
        test_back_to_back();
        test_trap_order();
        test_trap_split();
        test_overflow();
        test_trap_overflow();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/cosim_commit_packer.md
# cosim_commit_packer

Sits directly upstream of the Dromajo co-simulation checker: it takes the core's per-cycle commit trace, whose valid lanes may be sparse, and compacts it into an in-order record FIFO. It drains the FIFO into registered, lowest-lane-first commit bundles for the checker. Interrupt/exception events are ordered after every instruction committed in the same or an earlier cycle, and the trap is emitted together with the last preceding record.

## Interface
- COMMIT_WIDTH, 2 — commit lanes on input and output
- XLEN, 64 — pc/wdata/mstatus/cause width
- INST_BITS, 32 — instruction width
- RD, 5 — destination register index width
- HARTID_LEN, 1 — hart id width
- DEPTH, 16 — record FIFO entries; power of two, ≥ COMMIT_WIDTH
- clock  in  1  clock
- reset  in  1  synchronous, active-low (0 = reset)
- in_valid  in  COMMIT_WIDTH  per-lane commit valid; holes allowed
- in_pc, in_wdata, in_mstatus  in  XLEN*COMMIT_WIDTH  per-lane fields, lane i at bits [(i+1)*XLEN-1 -: XLEN]
- in_inst  in  INST_BITS*COMMIT_WIDTH  per-lane instruction
- in_check, in_wdata_valid, in_insn_writes_back  in  COMMIT_WIDTH  per-lane flags
- in_wdata_dest, in_insn_wdata_dest  in  RD*COMMIT_WIDTH  per-lane register indices
- in_int_xcpt  in  1  trap taken this cycle, ordered after this cycle's commits
- in_cause  in  XLEN  trap cause
- in_hartid  in  HARTID_LEN  hart id; registered through to out_hartid
- out_ready  in  1  checker may accept a bundle this cycle
- out_valid … out_insn_wdata_dest  out  same widths as the in_* fields  packed bundle; lanes 0..k-1 valid, contiguous
- out_int_xcpt  out  1  trap pulse, consumed after this cycle's out lanes
- out_cause  out  XLEN  cause for out_int_xcpt
- out_hartid  out  HARTID_LEN  hart id
- overflow  out  1  sticky: a commit group was dropped
- trap_overflow  out  1  sticky: a trap was dropped

## Operation
- Enqueue:
  - n = popcount(in_valid); valid lanes are written at consecutive FIFO slots in ascending lane order.
  - The group is accepted if occ − pop + n ≤ DEPTH, where pop is this cycle's dequeue count.
  - Otherwise the whole group is dropped and overflow is set; no partial enqueue.
- Dequeue (when out_ready = 1): pop = min(occ, COMMIT_WIDTH, trap_pend ? trap_cnt : COMMIT_WIDTH).
  - Popped records load out lanes 0..pop-1; higher lanes get out_valid = 0.
  - Data on invalid lanes is don't-care.
- Trap pending state: trap_pend, trap_cnt (width clog2(DEPTH+1)), trap_cause.
- On in_int_xcpt with trap_pend = 0, or with the pending trap being emitted this cycle:
  - trap_pend ← 1, trap_cause ← in_cause.
  - trap_cnt ← occ − pop + accepted n, i.e. records ahead of it.
- While pending and not emitting: trap_cnt ← trap_cnt − pop.
- Emit: when trap_pend, out_ready = 1, and pop = trap_cnt (including trap_cnt = 0):
  - out_int_xcpt ← 1, out_cause ← trap_cause, trap_pend ← 0.
- in_int_xcpt while a trap is pending and not emitting this cycle: the new trap is dropped and trap_overflow is set.
- Trap ordering is preserved even if its own commit group overflowed; the trap still counts only accepted records.
- out_ready = 0:
  - Output registers load out_valid = 0 and out_int_xcpt = 0.
  - No pops occur; the FIFO and trap counter hold.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- occ is tracked separately, range 0..DEPTH; full and empty are derived from occ.

## Timing
- All outputs are registered.
- Reset (reset = 0 at a rising edge):
  - Outputs: out_valid = 0, out_int_xcpt = 0, out_cause = 0, out_hartid = 0, overflow = 0, trap_overflow = 0.
  - State: occ = 0, pointers = 0, trap_pend = 0.
  - Inputs are ignored during reset.
- Reset mid-operation discards all queued records and any pending trap; nothing is emitted afterwards.
- Latency:
  - A group presented in cycle T is written at the end of T.
  - With an empty FIFO and out_ready = 1, the earliest it appears on the outputs is cycle T+2.
- Throughput: up to COMMIT_WIDTH records per cycle, in and out.
- The same-cycle enqueue and dequeue check uses the post-pop occupancy.

## Test plan
- Sparse lanes:
  - Stimulus: COMMIT_WIDTH = 2, in_valid = 2'b10 with pc 0x8000_0004 in lane 1; out_ready = 1.
  - Response: at T+2, out_valid = 2'b01 and out_pc lane 0 = 0x8000_0004.
- Trap ordering:
  - Stimulus: cycle T has in_valid = 2'b11 (pc 0x100, 0x104) plus in_int_xcpt with cause 0x8000_0000_0000_0007.
  - Response: out bundle with both records and out_int_xcpt = 1 in the same cycle, cause matching.
- Trap split:
  - Stimulus: 3 records queued, out_ready held 0, then a trap, then out_ready = 1.
  - Response: a bundle of 2 records; then a bundle of 1 record with out_int_xcpt = 1.
- Overflow:
  - Stimulus: DEPTH = 16, out_ready = 0, 9 cycles of 2'b11.
  - Response: 16 records are kept, overflow = 1 after the 9th group, and exactly the first 16 pcs drain in order.
- Trap overflow: two traps in consecutive cycles while out_ready = 0 → trap_overflow = 1; only the first trap is emitted.
- Reset mid-stream: reset = 0 with 5 records and a trap pending → all outputs 0; after release, no stale records or trap appear.
